freq_meter: RTL and testbench

Measures the frequency of a slow single-bit signal, such as an audio sample strobe or a divided clock, against the system clock. It counts rising edges of `sig_in` over a fixed gate window of `GATE_CYCLES` system-clock cycles. With the default gate of one second, the latched count is the frequency in Hz. It sits beside the clock-generation logic as a self-check and debug instrument, and its `count`/`done` outputs feed display or logging logic.

---
 rtl/freq_meter_pkg.sv | 5 +
 rtl/edge_sync.sv | 24 ++
 rtl/freq_meter.sv | 84 ++++++++
 tb/tb_freq_meter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared counter width and FSM state type for freq_meter
package freq_meter_pkg;
  localparam int COUNT_W = 32;
  typedef enum logic [1:0] {IDLE, COUNT, LATCH} fm_state_t;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: rising-edge detector for sig_in; FREQ_METER_SYNC_EN adds a two-flop synchronizer
module edge_sync (
  input  logic in_clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic rise
);
  logic sig_s, sig_prev_q, sig_prev_d;
`ifdef FREQ_METER_SYNC_EN
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], sig_in};
  always_ff @(posedge in_clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif
  always_comb sig_prev_d = sig_s;
  always_ff @(posedge in_clk or negedge reset_n)
    if (!reset_n) sig_prev_q <= 1'b0;
    else sig_prev_q <= sig_prev_d;
  assign rise = sig_s & ~sig_prev_q;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over a GATE_CYCLES window; FREQ_METER_SYNC_EN enables input sync
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter logic [31:0] IN_CLOCK_FREQ = 32'd50_000_000,
  parameter logic [31:0] GATE_CYCLES   = IN_CLOCK_FREQ
) (
  input  logic               in_clk,
  input  logic               reset_n,
  input  logic               sig_in,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(GATE_CYCLES - 32'd1);
  localparam logic [COUNT_W-1:0] MAX  = '1;
  fm_state_t state_q, state_d;
  logic [COUNT_W-1:0] gate_q, gate_d, edge_q, edge_d, count_q, count_d, edge_inc;
  logic sat_q, sat_d, overflow_q, overflow_d, sat_inc, rise;

  edge_sync u_edge_sync (.in_clk(in_clk), .reset_n(reset_n), .sig_in(sig_in), .rise(rise));

  always_comb begin
    edge_inc   = (rise && edge_q != MAX) ? edge_q + COUNT_W'(1) : edge_q;
    sat_inc    = sat_q | (rise & (edge_q == MAX));
    state_d    = state_q;
    gate_d     = gate_q;
    edge_d     = edge_q;
    sat_d      = sat_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (start | continuous) begin
        state_d = COUNT;
        gate_d  = '0;
        edge_d  = '0;
        sat_d   = 1'b0;
      end
      COUNT: begin
        gate_d = gate_q + COUNT_W'(1);
        edge_d = edge_inc;
        sat_d  = sat_inc;
        // results are captured on entry to LATCH so they are valid while done is high
        if (gate_q == LAST) begin
          state_d    = LATCH;
          count_d    = edge_inc;
          overflow_d = sat_inc;
        end
      end
      LATCH: begin
        state_d = continuous ? COUNT : IDLE;
        gate_d  = COUNT_W'(1);
        edge_d  = {{(COUNT_W-1){1'b0}}, rise};
        sat_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_q     <= gate_d;
      edge_q     <= edge_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end

  assign busy     = state_q != IDLE;
  assign done     = state_q == LATCH;
  assign count    = count_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed/random bench for freq_meter against an edge-history reference model
module tb_freq_meter;
  localparam int G = 100;
`ifdef FREQ_METER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  logic clk = 0, rst_n = 0, sig_in = 0, start = 0, continuous = 0;
  logic busy, done, overflow;
  logic [31:0] count;
  int cyc = 0, n_chk = 0, n_fail = 0, mode = 0, per = 2, ph = 0;
  bit lvl = 0;
  bit hist [0:19999];

  freq_meter #(.GATE_CYCLES(32'd100)) dut (
    .in_clk(clk), .reset_n(rst_n), .sig_in(sig_in), .start(start),
    .continuous(continuous), .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // hist[e] is the sig_in value sampled at posedge number e
  always @(posedge clk) begin
    if (cyc < 20000) hist[cyc] <= sig_in;
    cyc <= cyc + 1;
  end

  function automatic bit gen();
    return mode == 0 ? lvl : mode == 1 ? bit'(((cyc + ph) % per) < per / 2) : bit'($urandom_range(0, 1));
  endfunction

  // rising edges the meter should see at posedges a..b, given the input-to-rise latency
  function automatic int model(int a, int b);
    int c = 0;
    for (int e = a; e <= b; e++) if (hist[e-D] && !hist[e-D-1]) c++;
    return c;
  endfunction

  task automatic tick();
    @(negedge clk);
    sig_in = gen();
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      tick();
      if (done === 1'b1) at = cyc;
    end
    chk("done_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic count_dones(input int len, output int seen);
    seen = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (done !== 1'b0) seen++;
    end
  endtask

  task automatic measure(string tag, int fixed);
    int n, at;
    tick();
    start = 1;
    n = cyc;
    tick();
    start = 0;
    wait_done(G + 20, at);
    chk({tag, "_latency"}, 32'(at - n), 32'(G + 1));
    chk({tag, "_count"}, count, 32'(model(n + 1, n + G)));
    if (fixed >= 0) chk({tag, "_count_fixed"}, count, 32'(fixed));
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, at, seen, sum;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1;
    repeat (3) tick();
    mode = 1; per = 10; ph = int'($urandom_range(0, 9));
    measure("p10", 10);
    mode = 0; lvl = 1;
    repeat (5) tick();
    measure("held_high", 0);
    mode = 2;
    repeat (3) measure("random", -1);
    mode = 1; per = 2; ph = int'($urandom_range(0, 1));
    measure("p2", 50);
    // reset in the middle of a window
    mode = 1; per = 10;
    tick();
    start = 1;
    tick();
    start = 0;
    repeat (40) tick();
    rst_n = 0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", count, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (3) tick();
    rst_n = 1;
    count_dones(120, seen);
    chk("midrst_no_done", 32'(seen), 32'd0);
    measure("after_rst", 10);
    // start re-pulsed mid-window must be ignored
    ph = int'($urandom_range(0, 9));
    tick();
    start = 1;
    n = cyc;
    tick();
    start = 0;
    repeat (29) tick();
    start = 1;
    tick();
    start = 0;
    wait_done(G + 20, at);
    chk("repulse_latency", 32'(at - n), 32'(G + 1));
    chk("repulse_count", count, 32'(model(n + 1, n + G)));
    chk("repulse_count_fixed", count, 32'd10);
    count_dones(110, seen);
    chk("repulse_single_done", 32'(seen), 32'd0);
    // continuous back-to-back windows
    per = 4; ph = int'($urandom_range(0, 3));
    tick();
    continuous = 1;
    n = cyc;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(G + 5, at);
      chk("cont_period", 32'(at - n), 32'((k + 1) * G + 1));
      chk("cont_count", count, 32'(model(n + 1 + k * G, n + (k + 1) * G)));
      chk("cont_count_fixed", count, 32'd25);
      sum += int'(count);
    end
    repeat (20) tick();
    continuous = 0;
    wait_done(G + 5, at);
    chk("cont_last_period", 32'(at - n), 32'(5 * G + 1));
    chk("cont_last_count", count, 32'd25);
    sum += int'(count);
    chk("cont_total_edges", 32'(sum), 32'(model(n + 1, n + 5 * G)));
    tick();
    chk("cont_idle_after", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
